// File: rtl/fpga_io_router_pkg.sv
// fpga_io_router_pkg: shared constants for the pad-to-fabric IO router.
//   - register offsets inside the 512 B Wishbone window
//   - MAP entry field positions
//   - reset value of one MAP entry
//   - index range check used by routing and status logic
package fpga_io_router_pkg;

  localparam logic [8:0] CTRL_OFF   = 9'h100;
  localparam logic [8:0] STATUS_OFF = 9'h104;

  // MAP entry: {OUT, EN, IDX[5:0]}
  localparam int MAP_IDX_W   = 6;
  localparam int MAP_EN_BIT  = 6;
  localparam int MAP_OUT_BIT = 7;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_GEN_BIT    = 1;

  localparam int STAT_DIRTY_BIT    = 0;
  localparam int STAT_CONFLICT_BIT = 1;
  localparam int STAT_BADIDX_BIT   = 2;
  localparam int STAT_CNT_LSB      = 8;
  localparam int COMMIT_CNT_W      = 8;

  // Pads below the fabric width start as enabled inputs onto the matching
  // fabric bit; the rest start disabled.
  function automatic logic [7:0] reset_map(input int p, input int num_fabric);
    logic [7:0] m;
    m = '0;
    if (p < num_fabric) begin
      m[MAP_EN_BIT]        = 1'b1;
      m[MAP_IDX_W-1:0]     = p[MAP_IDX_W-1:0];
    end
    return m;
  endfunction

  function automatic logic idx_valid(input logic [MAP_IDX_W-1:0] idx, input int num_fabric);
    return 32'(idx) < num_fabric;
  endfunction

endpackage

// File: rtl/fpga_io_router_io_sync.sv
// io_sync: STAGES-deep flop chain per bit for asynchronous pad inputs.
//   gclk : clock
//   rst  : synchronous active-high reset, clears every stage
//   d    : asynchronous input vector
//   q    : synchronized output, STAGES cycles behind d
module io_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge gclk) begin
    if (rst) begin
      stg <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/fpga_io_router.sv
// fpga_io_router: Wishbone-programmable router between Caravel pads and the
// fabric edges. Software stages per-pad MAP entries in shadow registers and
// copies them all to the active set with one CTRL.COMMIT write.
//   wb_clk_i / wb_rst_i : clock, synchronous active-high reset
//   wbs_*               : Wishbone classic slave, 512 B window at BASE_ADDR
//   io_in/io_out/io_oeb : pad side (oeb active low)
//   fabric_in           : synchronized pad data to the fabric (N,S,E,W, LSB first)
//   fabric_out/fabric_oe: fabric drive data and drive request
module fpga_io_router
  import fpga_io_router_pkg::*;
#(
  parameter int          NUM_PADS    = 38,
  parameter int          IO_NORTH    = 10,
  parameter int          IO_SOUTH    = 8,
  parameter int          IO_EAST     = 10,
  parameter int          IO_WEST     = 10,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3010_0000,
  localparam int         NUM_FABRIC  = IO_NORTH + IO_SOUTH + IO_EAST + IO_WEST
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic [NUM_PADS-1:0]   io_in,
  output logic [NUM_PADS-1:0]   io_out,
  output logic [NUM_PADS-1:0]   io_oeb,
  output logic [NUM_FABRIC-1:0] fabric_in,
  input  logic [NUM_FABRIC-1:0] fabric_out,
  input  logic [NUM_FABRIC-1:0] fabric_oe
);

  logic [NUM_PADS-1:0][7:0]  shadow_map, active_map;
  logic                      gen;
  logic [COMMIT_CNT_W-1:0]   commit_cnt;
  logic                      conflict, badidx;

  logic                      accept, in_win, is_map, is_ctrl, is_status;
  logic                      wr_map, wr_ctrl, do_commit;
  logic [8:0]                off;
  logic [6:0]                word;
  logic [31:0]               rdata;

  logic                      dirty, conf_c, bad_c;
  logic [NUM_FABRIC-1:0]     claimed;
  logic [NUM_PADS-1:0]       pad_sync, io_out_d, io_oeb_d;

  logic                      unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

  // ---------------- Wishbone decode ----------------
  // ack itself blocks re-acceptance, so a held strobe completes every 2 cycles.
  assign accept    = wbs_stb_i && wbs_cyc_i && !wbs_ack_o;
  assign in_win    = wbs_adr_i[31:9] == BASE_ADDR[31:9];
  assign off       = wbs_adr_i[8:0];
  assign word      = off[8:2];
  assign is_map    = !off[8] && (32'(word) < NUM_PADS);
  assign is_ctrl   = word == CTRL_OFF[8:2];
  assign is_status = word == STATUS_OFF[8:2];

  assign wr_map    = accept && wbs_we_i && in_win && wbs_sel_i[0] && is_map;
  assign wr_ctrl   = accept && wbs_we_i && in_win && wbs_sel_i[0] && is_ctrl;
  assign do_commit = wr_ctrl && wbs_dat_i[CTRL_COMMIT_BIT];

  assign dirty = shadow_map != active_map;

  always_comb begin
    rdata = '0;
    if (in_win) begin
      if (is_map) begin
        rdata[7:0] = shadow_map[word[5:0]];
      end else if (is_ctrl) begin
        rdata[CTRL_GEN_BIT] = gen;
      end else if (is_status) begin
        rdata[STAT_DIRTY_BIT]                   = dirty;
        rdata[STAT_CONFLICT_BIT]                = conflict;
        rdata[STAT_BADIDX_BIT]                  = badidx;
        rdata[STAT_CNT_LSB +: COMMIT_CNT_W]     = commit_cnt;
      end
    end
  end

  // Flags of the shadow set; it becomes the active set on commit, so these
  // are what STATUS latches at that edge.
  always_comb begin
    claimed = '0;
    conf_c  = 1'b0;
    bad_c   = 1'b0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (shadow_map[p][MAP_EN_BIT]) begin
        if (!idx_valid(shadow_map[p][MAP_IDX_W-1:0], NUM_FABRIC)) begin
          bad_c = 1'b1;
        end else if (!shadow_map[p][MAP_OUT_BIT]) begin
          if (claimed[shadow_map[p][MAP_IDX_W-1:0]]) conf_c = 1'b1;
          claimed[shadow_map[p][MAP_IDX_W-1:0]] = 1'b1;
        end
      end
    end
  end

  // ---------------- Input path ----------------
  io_sync #(.WIDTH(NUM_PADS), .STAGES(SYNC_STAGES)) u_sync (
    .gclk (wb_clk_i),
    .rst  (wb_rst_i),
    .d    (io_in),
    .q    (pad_sync)
  );

  // Walk from the highest pad down so the lowest-numbered pad lands last
  // and wins a shared fabric index.
  always_comb begin
    fabric_in = '0;
    for (int p = NUM_PADS - 1; p >= 0; p--) begin
      if (active_map[p][MAP_EN_BIT] && !active_map[p][MAP_OUT_BIT] &&
          idx_valid(active_map[p][MAP_IDX_W-1:0], NUM_FABRIC))
        fabric_in[active_map[p][MAP_IDX_W-1:0]] = pad_sync[p];
    end
  end

  // ---------------- Output path ----------------
  always_comb begin
    io_out_d = '0;
    io_oeb_d = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (gen && active_map[p][MAP_EN_BIT] && active_map[p][MAP_OUT_BIT] &&
          idx_valid(active_map[p][MAP_IDX_W-1:0], NUM_FABRIC)) begin
        io_out_d[p] = fabric_out[active_map[p][MAP_IDX_W-1:0]];
        io_oeb_d[p] = !fabric_oe[active_map[p][MAP_IDX_W-1:0]];
      end
    end
  end

  // ---------------- State ----------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      gen        <= 1'b0;
      commit_cnt <= '0;
      conflict   <= 1'b0;
      badidx     <= 1'b0;
      io_out     <= '0;
      io_oeb     <= '1;
      for (int p = 0; p < NUM_PADS; p++) begin
        shadow_map[p] <= reset_map(p, NUM_FABRIC);
        active_map[p] <= reset_map(p, NUM_FABRIC);
      end
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept && !wbs_we_i) ? rdata : '0;
      io_out    <= io_out_d;
      io_oeb    <= io_oeb_d;
      if (wr_map) shadow_map[word[5:0]] <= wbs_dat_i[7:0];
      if (wr_ctrl) gen <= wbs_dat_i[CTRL_GEN_BIT];
      if (do_commit) begin
        active_map <= shadow_map;
        commit_cnt <= commit_cnt + 1'b1;
        conflict   <= conf_c;
        badidx     <= bad_c;
      end
    end
  end

endmodule

// File: tb/tb_fpga_io_router.sv
module tb_fpga_io_router;

  localparam int          NP   = 38;
  localparam int          NF   = 38;
  localparam int          SYNC = 2;
  localparam logic [31:0] BASE = 32'h3010_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   dat_i = '0, adr = '0;
  logic          ack;
  logic [31:0]   dat_o;
  logic [NP-1:0] io_in = '0;
  logic [NP-1:0] io_out, io_oeb;
  logic [NF-1:0] fabric_in;
  logic [NF-1:0] fabric_out = '0, fabric_oe = '0;

  always #5 clk = ~clk;

  fpga_io_router dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .fabric_in(fabric_in), .fabric_out(fabric_out), .fabric_oe(fabric_oe)
  );

  // ---------------- Reference model ----------------
  typedef struct { bit is_rd; logic [31:0] data; } exp_t;
  exp_t sb[$];

  int            m_sh[NP], m_act[NP];   // MAP bytes as plain integers
  bit            m_gen, m_conf, m_bad, m_ack;
  int            m_cnt;
  logic [NP-1:0] hq[$];                 // last SYNC samples of io_in, oldest first
  logic [NP-1:0] exp_out, exp_oeb;
  logic [NF-1:0] exp_fin;

  int  n_checks = 0, n_err = 0, stall = 0;
  bit  chk_en = 1'b0, rnd_pads = 1'b0;

  function automatic int idx_of(input int v); return v % 64; endfunction
  function automatic bit en_of(input int v);  return ((v / 64) % 2) == 1; endfunction
  function automatic bit out_of(input int v); return (v / 128) == 1; endfunction
  function automatic bit is_in(input int v);
    return en_of(v) && !out_of(v) && idx_of(v) < NF;
  endfunction

  always @(posedge clk) begin
    logic [NP-1:0] nout, noeb, sq;
    logic [NF-1:0] fin;
    logic [31:0]   rdat;
    int            off, w, cnt_in;
    bit            acc, inw, dirty, found;
    nout = '0;
    noeb = '1;
    for (int p = 0; p < NP; p++)
      if (en_of(m_act[p]) && out_of(m_act[p]) && m_gen && idx_of(m_act[p]) < NF) begin
        nout[p] = fabric_out[idx_of(m_act[p])];
        noeb[p] = !fabric_oe[idx_of(m_act[p])];
      end
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        m_sh[p]  = (p < NF) ? 64 + p : 0;
        m_act[p] = m_sh[p];
      end
      m_gen = 0; m_cnt = 0; m_conf = 0; m_bad = 0; m_ack = 0;
      sb.delete();
      hq.delete();
      repeat (SYNC) hq.push_back('0);
      nout = '0;
      noeb = '1;
    end else begin
      acc = stb && cyc && !m_ack;
      if (acc) begin
        off  = {23'b0, adr[8:0]};
        w    = off / 4;
        inw  = adr[31:9] == BASE[31:9];
        rdat = '0;
        if (inw) begin
          if (off < 256 && w < NP) rdat = m_sh[w];
          else if (w == 64) rdat = m_gen ? 2 : 0;
          else if (w == 65) begin
            dirty = 0;
            for (int p = 0; p < NP; p++) if (m_sh[p] != m_act[p]) dirty = 1;
            rdat = m_cnt * 256 + (m_bad ? 4 : 0) + (m_conf ? 2 : 0) + (dirty ? 1 : 0);
          end
        end
        sb.push_back('{is_rd: !we, data: rdat});
        if (we && inw && sel[0]) begin
          if (off < 256 && w < NP) m_sh[w] = {24'b0, dat_i[7:0]};
          else if (w == 64) begin
            m_gen = dat_i[1];
            if (dat_i[0]) begin
              m_act = m_sh;
              m_cnt = (m_cnt + 1) % 256;
              m_conf = 0;
              m_bad  = 0;
              for (int f = 0; f < NF; f++) begin
                cnt_in = 0;
                for (int p = 0; p < NP; p++) if (is_in(m_act[p]) && idx_of(m_act[p]) == f) cnt_in++;
                if (cnt_in > 1) m_conf = 1;
              end
              for (int p = 0; p < NP; p++) if (en_of(m_act[p]) && idx_of(m_act[p]) >= NF) m_bad = 1;
            end
          end
        end
      end
      m_ack = acc;
      hq.push_back(io_in);
      void'(hq.pop_front());
    end
    sq  = hq[0];
    fin = '0;
    for (int f = 0; f < NF; f++) begin
      found = 0;
      for (int p = 0; p < NP; p++)
        if (!found && is_in(m_act[p]) && idx_of(m_act[p]) == f) begin
          fin[f] = sq[p];
          found  = 1;
        end
    end
    exp_out = nout;
    exp_oeb = noeb;
    exp_fin = fin;
  end

  // ---------------- Monitor / scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      chk("ack", 64'(ack), 64'(m_ack));
      if (ack) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_empty: ack with no transfer outstanding at %0t", $time);
        end else begin
          e = sb.pop_front();
          if (e.is_rd) chk("rdata", 64'(dat_o), 64'(e.data));
        end
      end else begin
        chk("dat_idle", 64'(dat_o), 64'(0));
      end
      stall = (stb && !ack) ? stall + 1 : 0;
      chk("ack_timeout", 64'(stall > 8), 64'(0));
      chk("fabric_in", 64'(fabric_in), 64'(exp_fin));
      chk("io_out", 64'(io_out), 64'(exp_out));
      chk("io_oeb", 64'(io_oeb), 64'(exp_oeb));
    end
  end

  // ---------------- Stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd_pads) begin
        io_in      = NP'({$urandom, $urandom});
        fabric_out = NF'({$urandom, $urandom});
        fabric_oe  = NF'({$urandom, $urandom});
      end
    end
  endtask

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int t;
    stb = 1; cyc = 1; we = w; adr = a; dat_i = d; sel = s;
    t = 0;
    do begin
      tick(1);
      t++;
    end while (!ack && t < 10);
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic commit(input bit g);
    wb(1, BASE + 32'h100, {30'b0, g, 1'b1}, 4'h1);
  endtask

  initial begin
    int op, p, v, ix;
    logic [3:0] s;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int op, p, v, ix;
    logic [3:0] s;
    tick(1);
    chk_en = 1;
    tick(2);
    rst = 0;
    tick(1);

    // reset readback and input path latency
    wb(0, BASE + 32'd20, 0, 4'hF);
    wb(0, BASE + 32'h104, 0, 4'hF);
    io_in[3] = 1'b1;
    tick(4);

    // staged output mapping, GEN live, then commit
    wb(1, BASE + 32'd48, 32'hC4, 4'h1);
    wb(1, BASE + 32'h100, 32'h2, 4'h1);
    wb(0, BASE + 32'h104, 0, 4'hF);
    fabric_out[4] = 1'b1;
    fabric_oe[4]  = 1'b1;
    tick(2);
    commit(1);
    tick(3);
    wb(0, BASE + 32'h104, 0, 4'hF);

    // two inputs on one fabric bit: lowest pad wins
    wb(1, BASE + 32'd8,  32'h47, 4'h1);
    wb(1, BASE + 32'd36, 32'h47, 4'h1);
    commit(1);
    io_in[9] = 1'b1; tick(3);
    io_in[2] = 1'b1; tick(3);
    io_in[9] = 1'b0; tick(3);
    io_in[2] = 1'b0; tick(3);
    wb(0, BASE + 32'h104, 0, 4'hF);

    // out-of-range index
    io_in[0] = 1'b1;
    tick(3);
    wb(1, BASE + 32'd0, 32'h7F, 4'h1);
    commit(1);
    tick(3);
    wb(0, BASE + 32'h104, 0, 4'hF);

    // unmapped and out-of-window accesses
    wb(0, BASE + 32'h1F0, 0, 4'hF);
    wb(1, BASE + 32'h1F0, 32'hFFFF_FFFF, 4'hF);
    wb(0, BASE + 32'h200, 0, 4'hF);
    wb(1, BASE + 32'h200, 32'h0, 4'h1);
    wb(0, BASE + 32'h108, 0, 4'hF);

    // commit counter wrap
    repeat (256) commit(1);
    wb(0, BASE + 32'h104, 0, 4'hF);

    // reset while a write ack is pending
    stb = 1; cyc = 1; we = 1; adr = BASE + 32'd20; dat_i = 32'h00; sel = 4'h1;
    tick(1);
    stb = 0; cyc = 0; we = 0; rst = 1;
    tick(1);
    rst = 0;
    tick(1);
    wb(0, BASE + 32'd20, 0, 4'hF);
    wb(0, BASE + 32'h104, 0, 4'hF);

    // randomized traffic
    rnd_pads = 1;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      p  = $urandom_range(0, NP - 1);
      s  = ($urandom_range(0, 7) == 0) ? 4'hE : 4'hF;
      ix = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NF - 1);
      v  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3) * 64 + ix;
      case (op)
        0, 1, 2, 3: wb(1, BASE + 32'(4 * p), 32'(v), s);
        4:          wb(1, BASE + 32'h100, {30'b0, 1'($urandom_range(0, 1)), 1'b1}, s);
        5:          wb(1, BASE + 32'h100, {30'b0, 1'($urandom_range(0, 1)), 1'b0}, s);
        6:          wb(0, BASE + 32'(4 * p), 0, s);
        7:          wb(0, BASE + 32'h104, 0, s);
        8:          wb(0, BASE + 32'h100, 0, s);
        default:    wb(1'($urandom_range(0, 1)), BASE + 32'(4 * $urandom_range(0, 127)), $urandom, s);
      endcase
      tick($urandom_range(0, 2));
    end
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
